// File: rtl/mem_arbiter.sv
// Arbitrates instruction-fetch and data ports onto one variable-latency RAM; data wins.
// Define ILAST_EN to add a one-entry last-fetch buffer that answers repeat fetches from IDLE.
module mem_arbiter #(
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned AW      = 32
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic          iREN,
    input  logic [AW-1:0] iaddr,
    output logic [AW-1:0] iload,
    output logic          ihit,
    input  logic          dREN,
    input  logic          dWEN,
    input  logic [AW-1:0] daddr,
    input  logic [AW-1:0] dstore,
    output logic [AW-1:0] dload,
    output logic          dhit,
    output logic          ramREN,
    output logic          ramWEN,
    output logic [AW-1:0] ramaddr,
    output logic [AW-1:0] ramstore,
    input  logic [AW-1:0] ramload,
    input  logic [1:0]    ramstate,
    output logic          err
);

    localparam int unsigned CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] TimeoutCnt = CW'(TIMEOUT);
    localparam logic [1:0] RamAccess = 2'd2;
    localparam logic [1:0] RamError  = 2'd3;

    typedef enum logic [1:0] {StIdle, StDacc, StIacc, StErr} state_e;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d, cnt_inc;
    logic          err_q;
    logic          d_req;

    assign d_req   = dREN | dWEN;
    assign cnt_inc = cnt_q + CW'(1);
    assign err     = err_q;

`ifdef ILAST_EN
    logic          buf_valid_q;
    logic [AW-1:0] buf_tag_q;
    logic [AW-1:0] buf_word_q;
    logic          buf_hit;

    assign buf_hit = iREN && !d_req && buf_valid_q && (iaddr == buf_tag_q);
`endif

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ramREN   = 1'b0;
        ramWEN   = 1'b0;
        ramaddr  = '0;
        ramstore = '0;
        ihit     = 1'b0;
        iload    = '0;
        dhit     = 1'b0;
        dload    = '0;
        unique case (state_q)
            StIdle: begin
                if (d_req) begin
                    state_d = StDacc;
                    cnt_d   = '0;
`ifdef ILAST_EN
                end else if (buf_hit) begin
                    ihit  = 1'b1;
                    iload = buf_word_q;
`endif
                end else if (iREN) begin
                    state_d = StIacc;
                    cnt_d   = '0;
                end
            end
            StDacc: begin
                ramaddr  = daddr;
                ramstore = dstore;
                if (dWEN) ramWEN = 1'b1;
                else      ramREN = 1'b1;
                if (ramstate == RamAccess) begin
                    dhit    = 1'b1;
                    dload   = ramload;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (ramstate == RamError) begin
                    state_d = StErr;
                end else if (!d_req) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutCnt) state_d = StErr;
                end
            end
            StIacc: begin
                ramaddr = iaddr;
                ramREN  = 1'b1;
                if (ramstate == RamAccess) begin
                    ihit    = 1'b1;
                    iload   = ramload;
                    state_d = StIdle;
                    cnt_d   = '0;
                end else if (ramstate == RamError) begin
                    state_d = StErr;
                end else if (!iREN) begin
                    state_d = StIdle;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TimeoutCnt) state_d = StErr;
                end
            end
            StErr: begin
                state_d = StErr;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= StIdle;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= (state_d == StErr);
        end
    end

`ifdef ILAST_EN
    // Fill only from real RAM returns; a write to the cached address drops the entry.
    always_ff @(posedge CLK) begin
        if (RST) begin
            buf_valid_q <= 1'b0;
            buf_tag_q   <= '0;
            buf_word_q  <= '0;
        end else if (state_q == StIacc && ramstate == RamAccess) begin
            buf_valid_q <= 1'b1;
            buf_tag_q   <= iaddr;
            buf_word_q  <= ramload;
        end else if (state_q == StDacc && ramstate == RamAccess && dWEN &&
                     daddr == buf_tag_q) begin
            buf_valid_q <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed self-checking bench for mem_arbiter (TIMEOUT=4); ILAST_EN checks follow the same macro.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        iREN, dREN, dWEN;
    logic [31:0] iaddr, daddr, dstore, ramload;
    logic [1:0]  ramstate;
    logic [31:0] iload, dload, ramaddr, ramstore;
    logic        ihit, dhit, ramREN, ramWEN, err;

    int tests = 0;
    int fails = 0;

    mem_arbiter #(.TIMEOUT(4), .AW(32)) dut (
        .CLK(CLK), .RST(RST),
        .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore), .dload(dload), .dhit(dhit),
        .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
        .ramload(ramload), .ramstate(ramstate), .err(err)
    );

    always #5 CLK = ~CLK;

    task automatic next_cycle;
        @(posedge CLK);
        #1;
    endtask

    task automatic sample;
        @(negedge CLK);
    endtask

    task automatic clear_inputs;
        iREN = 0; dREN = 0; dWEN = 0;
        iaddr = 0; daddr = 0; dstore = 0; ramload = 0; ramstate = 0;
    endtask

    task automatic pulse_reset;
        clear_inputs();
        RST = 1;
        next_cycle();
        RST = 0;
    endtask

    task automatic test_reset;
        pulse_reset();
        sample();
        tests++;
        if (ramREN !== 1'b0 || ramWEN !== 1'b0 || ramaddr !== 32'h0 || ramstore !== 32'h0) begin
            fails++;
            $display("FAIL reset_ram: got ren=%b wen=%b addr=%h store=%h want all 0",
                     ramREN, ramWEN, ramaddr, ramstore);
        end
        tests++;
        if (ihit !== 1'b0 || dhit !== 1'b0 || err !== 1'b0 || iload !== 0 || dload !== 0) begin
            fails++;
            $display("FAIL reset_outs: got ihit=%b dhit=%b err=%b want 0", ihit, dhit, err);
        end
        next_cycle();
    endtask

    task automatic test_fetch;
        logic [1:0]  rs[5]      = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd0};
        logic        exp_hit[5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
        logic        exp_ren[5] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
        int ren_cnt = 0;
        int hit_cnt = 0;
        clear_inputs();
        iREN = 1; iaddr = 32'h0000_0040;
        for (int c = 0; c < 5; c++) begin
            ramstate = rs[c];
            ramload  = (c == 3) ? 32'h2002_0001 : 32'h0;
            if (c == 4) iREN = 0;
            sample();
            tests++;
            if (ihit !== exp_hit[c] || ramREN !== exp_ren[c]) begin
                fails++;
                $display("FAIL fetch_c%0d: got ihit=%b ren=%b want ihit=%b ren=%b",
                         c, ihit, ramREN, exp_hit[c], exp_ren[c]);
            end
            tests++;
            if (iload !== ((c == 3) ? 32'h2002_0001 : 32'h0)) begin
                fails++;
                $display("FAIL fetch_iload_c%0d: got %h", c, iload);
            end
            if (c == 1) begin
                tests++;
                if (ramaddr !== 32'h40) begin
                    fails++;
                    $display("FAIL fetch_addr: got %h want 00000040", ramaddr);
                end
            end
            ren_cnt += int'(ramREN);
            hit_cnt += int'(ihit);
            next_cycle();
        end
        tests++;
        if (ren_cnt != 3 || hit_cnt != 1) begin
            fails++;
            $display("FAIL fetch_counts: got ren=%0d hit=%0d want ren=3 hit=1", ren_cnt, hit_cnt);
        end
    endtask

    task automatic test_priority;
        clear_inputs();
        iREN = 1; iaddr = 32'h80; dREN = 1; daddr = 32'h100;
        sample();
        tests++;
        if (ramREN !== 1'b0) begin
            fails++;
            $display("FAIL prio_bubble: got ren=%b want 0", ramREN);
        end
        next_cycle();
        ramstate = 2; ramload = 32'h11;
        sample();
        tests++;
        if (dhit !== 1'b1 || ihit !== 1'b0 || dload !== 32'h11 || ramaddr !== 32'h100) begin
            fails++;
            $display("FAIL prio_data_first: got dhit=%b ihit=%b dload=%h addr=%h want 1 0 11 100",
                     dhit, ihit, dload, ramaddr);
        end
        next_cycle();
        dREN = 0; ramstate = 0; ramload = 0;
        sample();
        tests++;
        if (ihit !== 1'b0 || dhit !== 1'b0 || ramREN !== 1'b0) begin
            fails++;
            $display("FAIL prio_gap: got ihit=%b dhit=%b ren=%b want 0 0 0", ihit, dhit, ramREN);
        end
        next_cycle();
        ramstate = 2; ramload = 32'h22;
        sample();
        tests++;
        if (ihit !== 1'b1 || dhit !== 1'b0 || iload !== 32'h22 || ramaddr !== 32'h80) begin
            fails++;
            $display("FAIL prio_fetch_second: got ihit=%b dhit=%b iload=%h addr=%h want 1 0 22 80",
                     ihit, dhit, iload, ramaddr);
        end
        next_cycle();
        clear_inputs();
        next_cycle();
    endtask

    task automatic test_write;
        clear_inputs();
        dREN = 1; dWEN = 1; daddr = 32'h200; dstore = 32'hDEAD_BEEF;
        next_cycle();
        ramstate = 1;
        sample();
        tests++;
        if (ramWEN !== 1'b1 || ramREN !== 1'b0 || ramstore !== 32'hDEAD_BEEF ||
            ramaddr !== 32'h200 || dhit !== 1'b0) begin
            fails++;
            $display("FAIL write_drive: got wen=%b ren=%b store=%h addr=%h dhit=%b",
                     ramWEN, ramREN, ramstore, ramaddr, dhit);
        end
        next_cycle();
        ramstate = 2;
        sample();
        tests++;
        if (dhit !== 1'b1 || ramWEN !== 1'b1) begin
            fails++;
            $display("FAIL write_hit: got dhit=%b wen=%b want 1 1", dhit, ramWEN);
        end
        next_cycle();
        clear_inputs();
        sample();
        tests++;
        if (dhit !== 1'b0 || ramWEN !== 1'b0) begin
            fails++;
            $display("FAIL write_release: got dhit=%b wen=%b want 0 0", dhit, ramWEN);
        end
        next_cycle();
    endtask

    task automatic test_abandon;
        clear_inputs();
        iREN = 1; iaddr = 32'h44; ramstate = 1;
        next_cycle();
        sample();
        tests++;
        if (ramREN !== 1'b1) begin
            fails++;
            $display("FAIL abandon_grant: got ren=%b want 1", ramREN);
        end
        next_cycle();
        iREN = 0;
        next_cycle();
        ramstate = 2; ramload = 32'h77;
        sample();
        tests++;
        if (ihit !== 1'b0 || ramREN !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL abandon_idle: got ihit=%b ren=%b err=%b want 0 0 0", ihit, ramREN, err);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_err_dacc;
        clear_inputs();
        dREN = 1; daddr = 32'h10;
        next_cycle();
        ramstate = 3;
        sample();
        tests++;
        if (dhit !== 1'b0 || err !== 1'b0) begin
            fails++;
            $display("FAIL errd_cycle: got dhit=%b err=%b want 0 0", dhit, err);
        end
        next_cycle();
        clear_inputs();
        iREN = 1; iaddr = 32'h8;
        sample();
        tests++;
        if (err !== 1'b1) begin
            fails++;
            $display("FAIL errd_raise: got err=%b want 1", err);
        end
        next_cycle();
        ramstate = 2;
        sample();
        tests++;
        if (err !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0) begin
            fails++;
            $display("FAIL errd_sticky: got err=%b ren=%b ihit=%b want 1 0 0", err, ramREN, ihit);
        end
        next_cycle();
        pulse_reset();
    endtask

    task automatic test_timeout;
        clear_inputs();
        iREN = 1; iaddr = 32'h300; ramstate = 1;
        next_cycle();
        for (int c = 1; c <= 4; c++) begin
            sample();
            tests++;
            if (err !== 1'b0 || ramREN !== 1'b1 || ihit !== 1'b0) begin
                fails++;
                $display("FAIL timeout_wait%0d: got err=%b ren=%b ihit=%b want 0 1 0",
                         c, err, ramREN, ihit);
            end
            next_cycle();
        end
        sample();
        tests++;
        if (err !== 1'b1 || ramREN !== 1'b0 || ihit !== 1'b0 || dhit !== 1'b0) begin
            fails++;
            $display("FAIL timeout_err: got err=%b ren=%b ihit=%b dhit=%b want 1 0 0 0",
                     err, ramREN, ihit, dhit);
        end
        next_cycle();
        dREN = 1; ramstate = 2;
        sample();
        tests++;
        if (dhit !== 1'b0 || ramREN !== 1'b0 || err !== 1'b1) begin
            fails++;
            $display("FAIL timeout_ignore: got dhit=%b ren=%b err=%b want 0 0 1", dhit, ramREN, err);
        end
        next_cycle();
        pulse_reset();
        sample();
        tests++;
        if (err !== 1'b0 || ramREN !== 1'b0) begin
            fails++;
            $display("FAIL timeout_reset: got err=%b ren=%b want 0 0", err, ramREN);
        end
        next_cycle();
    endtask

    task automatic test_reset_mid;
        clear_inputs();
        dREN = 1; daddr = 32'h20; ramstate = 1;
        next_cycle();
        RST = 1;
        next_cycle();
        RST = 0;
        dREN = 0;
        sample();
        tests++;
        if (ramREN !== 1'b0 || ramaddr !== 32'h0) begin
            fails++;
            $display("FAIL reset_mid: got ren=%b addr=%h want 0 0", ramREN, ramaddr);
        end
        next_cycle();
        clear_inputs();
    endtask

    task automatic test_last_fetch;
        clear_inputs();
        iREN = 1; iaddr = 32'h40;
        next_cycle();
        ramstate = 2; ramload = 32'h55;
        sample();
        tests++;
        if (ihit !== 1'b1 || iload !== 32'h55) begin
            fails++;
            $display("FAIL last_first: got ihit=%b iload=%h want 1 55", ihit, iload);
        end
        next_cycle();
        ramstate = 0; ramload = 32'h99;
        sample();
`ifdef ILAST_EN
        tests++;
        if (ihit !== 1'b1 || iload !== 32'h55 || ramREN !== 1'b0) begin
            fails++;
            $display("FAIL last_buffer_hit: got ihit=%b iload=%h ren=%b want 1 55 0",
                     ihit, iload, ramREN);
        end
        next_cycle();
        iREN = 0; dWEN = 1; daddr = 32'h40; dstore = 32'h1;
        next_cycle();
        ramstate = 2;
        sample();
        tests++;
        if (dhit !== 1'b1 || ramWEN !== 1'b1) begin
            fails++;
            $display("FAIL last_write: got dhit=%b wen=%b want 1 1", dhit, ramWEN);
        end
        next_cycle();
        dWEN = 0; ramstate = 0; iREN = 1; iaddr = 32'h40;
        sample();
        tests++;
        if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            fails++;
            $display("FAIL last_invalidated: got ihit=%b ren=%b want 0 0", ihit, ramREN);
        end
        next_cycle();
        ramstate = 1;
`else
        tests++;
        if (ihit !== 1'b0 || ramREN !== 1'b0) begin
            fails++;
            $display("FAIL nobuf_bubble: got ihit=%b ren=%b want 0 0", ihit, ramREN);
        end
        next_cycle();
        ramstate = 1;
`endif
        sample();
        tests++;
        if (ramREN !== 1'b1 || ramaddr !== 32'h40 || ihit !== 1'b0) begin
            fails++;
            $display("FAIL last_refetch: got ren=%b addr=%h ihit=%b want 1 40 0",
                     ramREN, ramaddr, ihit);
        end
        next_cycle();
        iREN = 0;
        next_cycle();
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        RST = 1;
        test_reset();
        test_fetch();
        test_priority();
        test_write();
        test_abandon();
        test_reset_mid();
        test_err_dacc();
        test_timeout();
        test_last_fetch();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
